// File: rtl/mix_cols_enc_seq.sv
// Column-serial forward AES MixColumns: one 32-bit column per clock through a shared
// datapath; the result is held until downstream takes it, with a short bypass for the final round.
module mix_cols_enc_seq (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         mix_col_en,
  input  logic [127:0] mc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] mc_o,
  output logic         busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   col_idx_reg;
  logic [127:0] work_reg;
  logic [127:0] result_reg;
  logic         mix_en_reg;

  logic [31:0]  cols [4];
  logic [31:0]  col_in;
  logic [31:0]  col_out;
  logic [7:0]   a  [4];
  logic [7:0]   x2 [4];
  logic [7:0]   x3 [4];

  // Column 0 sits in the top word; byte 0 of a column is its MSB byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_col_split
      assign cols[gi] = work_reg[127-32*gi -: 32];
    end
  endgenerate

  assign col_in = cols[col_idx_reg];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_xtime
      assign a[gi]  = col_in[31-8*gi -: 8];
      assign x2[gi] = {a[gi][6:0], 1'b0} ^ (a[gi][7] ? 8'h1B : 8'h00);
      assign x3[gi] = x2[gi] ^ a[gi];
    end
  endgenerate

  assign col_out = {x2[0] ^ x3[1] ^ a[2]  ^ a[3],
                    a[0]  ^ x2[1] ^ x3[2] ^ a[3],
                    a[0]  ^ a[1]  ^ x2[2] ^ x3[3],
                    x3[0] ^ a[1]  ^ a[2]  ^ x2[3]};

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (in_valid) state_next = CALC;
      // Bypass spends a single CALC cycle copying the captured state to the output.
      CALC: if (!mix_en_reg || (col_idx_reg == 2'd3)) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      col_idx_reg <= 2'd0;
      work_reg    <= 128'h0;
      result_reg  <= 128'h0;
      mix_en_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == IDLE) && in_valid) begin
        work_reg    <= mc_i;
        mix_en_reg  <= mix_col_en;
        col_idx_reg <= 2'd0;
      end
      if (state_reg == CALC) begin
        if (mix_en_reg) begin
          case (col_idx_reg)
            2'd0: result_reg[127:96] <= col_out;
            2'd1: result_reg[95:64]  <= col_out;
            2'd2: result_reg[63:32]  <= col_out;
            default: result_reg[31:0] <= col_out;
          endcase
          col_idx_reg <= col_idx_reg + 2'd1;
        end else begin
          result_reg <= work_reg;
        end
      end
    end
  end

  assign mc_o      = result_reg;
  assign in_ready  = (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign busy      = (state_reg == CALC) || (state_reg == DONE);

endmodule

// File: tb/tb_mix_cols_enc_seq.sv
// Bench for mix_cols_enc_seq: directed and random states checked against a GF(2^8)
// matrix model of MixColumns and its inverse.
module tb_mix_cols_enc_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic         mix_col_en;
  logic [127:0] mc_i;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] mc_o;
  logic         busy;

  int total = 0;
  int bad   = 0;

  mix_cols_enc_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mix_col_en (mix_col_en),
    .mc_i       (mc_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .mc_o       (mc_o),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // General GF(2^8) multiply, shift-and-add over the AES polynomial.
  function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
    logic [7:0] p  = 8'h00;
    logic [7:0] xx = x;
    logic [7:0] yy = y;
    for (int i = 0; i < 8; i++) begin
      if (yy[0]) p = p ^ xx;
      xx = {xx[6:0], 1'b0} ^ (xx[7] ? 8'h1B : 8'h00);
      yy = yy >> 1;
    end
    return p;
  endfunction

  // Circulant matrix product on every column; inv selects the inverse matrix.
  function automatic logic [127:0] mix_model(input logic [127:0] s, input bit inv);
    logic [7:0]   coef [4];
    logic [127:0] r = 128'h0;
    logic [7:0]   acc;
    if (inv) begin
      coef[0] = 8'h0E; coef[1] = 8'h0B; coef[2] = 8'h0D; coef[3] = 8'h09;
    end else begin
      coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
    end
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(coef[(j - row + 4) % 4], s[127 - 32*c - 8*j -: 8]);
        r[127 - 32*c - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction with out_ready held high; checks latency and the handoff cycle.
  task automatic transact(input string tag, input logic [127:0] st, input logic en,
                          output logic [127:0] res);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1; mc_i = st; mix_col_en = en; out_ready = 1;
    @(negedge clk);
    in_valid = 0; mc_i = rand128(); mix_col_en = ~en;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, lat, en ? 4 : 1);
    res = mc_o;
    @(negedge clk);
    chk({tag, "_ov_1cyc"}, out_valid, 0);
    chk({tag, "_ready_back"}, in_ready, 1);
    chk({tag, "_hold"}, mc_o, res);
    $display("txn %s in=%h en=%0d out=%h lat=%0d", tag, st, en, res, lat);
  endtask

  logic [127:0] res, st, held, sa, sb;
  logic [31:0]  kv_in  [6];
  logic [31:0]  kv_out [6];
  int lat;

  initial begin
    kv_in[0] = 32'hdb135345; kv_out[0] = 32'h8e4da1bc;
    kv_in[1] = 32'hf20a225c; kv_out[1] = 32'h9fdc589d;
    kv_in[2] = 32'h01010101; kv_out[2] = 32'h01010101;
    kv_in[3] = 32'hc6c6c6c6; kv_out[3] = 32'hc6c6c6c6;
    kv_in[4] = 32'hd4d4d4d5; kv_out[4] = 32'hd5d5d7d6;
    kv_in[5] = 32'h2d26314c; kv_out[5] = 32'h4d7ebdf8;

    rst_n = 0; in_valid = 0; mix_col_en = 0; mc_i = 128'h0; out_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_mc_o", mc_o, 128'h0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1;

    transact("fips", 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 1'b1, res);
    chk("fips_result", res, 128'h046681e5_e0cb199a_48f8d37a_2806264c);

    for (int v = 0; v < 6; v++) begin
      for (int p = 0; p < 4; p++) begin
        st = rand128();
        st[127 - 32*p -: 32] = kv_in[v];
        transact("kat", st, 1'b1, res);
        chk("kat_column", res[127 - 32*p -: 32], kv_out[v]);
        chk("kat_state", res, mix_model(st, 0));
      end
    end

    transact("bypass", 128'h00112233_44556677_8899aabb_ccddeeff, 1'b0, res);
    chk("bypass_result", res, 128'h00112233_44556677_8899aabb_ccddeeff);

    // Backpressure: second state waits at the input while the first is held.
    sa = rand128(); sb = rand128();
    @(negedge clk);
    in_valid = 1; mc_i = sa; mix_col_en = 1; out_ready = 0;
    @(negedge clk);
    mc_i = sb;
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_latency", lat, 4);
    held = mc_o;
    chk("bp_first", held, mix_model(sa, 0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_mc_o", mc_o, held);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    out_ready = 1;
    @(negedge clk);
    chk("bp_handoff_ov", out_valid, 0);
    chk("bp_handoff_ready", in_ready, 1);
    chk("bp_handoff_hold", mc_o, held);
    @(negedge clk);
    in_valid = 0;
    chk("bp_second_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 12) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_second_latency", lat, 4);
    chk("bp_second", mc_o, mix_model(sb, 0));
    $display("txn backpressure a=%h b=%h out=%h", sa, sb, mc_o);
    @(negedge clk);

    // Reset right after column 2 has been written.
    st = rand128();
    @(negedge clk);
    in_valid = 1; mc_i = st; mix_col_en = 1; out_ready = 1;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("mrst_mc_o", mc_o, 128'h0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready", in_ready, 1);
    rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mrst_no_spurious", out_valid, 0);
    end
    $display("txn midreset in=%h", st);
    st = rand128();
    transact("after_rst", st, 1'b1, res);
    chk("after_rst_result", res, mix_model(st, 0));

    for (int n = 0; n < 200; n++) begin
      st = rand128();
      transact("roundtrip", st, 1'b1, res);
      chk("rt_fwd", res, mix_model(st, 0));
      chk("rt_inv", mix_model(res, 1), st);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
